// File: rtl/multdiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide units:
// FSM state encoding, radix-4 Booth digit encoding and the digit decoder.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_digit_e;

    // Map the overlapping triplet {q[1], q[0], q[-1]} to a Booth digit in {-2..+2}.
    function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
        booth_digit_e digit;
        case (triplet)
            3'b001, 3'b010: digit = BOOTH_POS1;
            3'b011:         digit = BOOTH_POS2;
            3'b100:         digit = BOOTH_NEG2;
            3'b101, 3'b110: digit = BOOTH_NEG1;
            default:        digit = BOOTH_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Request/response bundle between the pipeline (master) and the multiplier (slave).
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   ready;
    logic                   busy;
    logic                   result_valid;
    logic [2*WIDTH-1:0]     product;
    logic                   overflow;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  ready, busy, result_valid, product, overflow
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output ready, busy, result_valid, product, overflow
    );
endinterface

// File: rtl/booth_radix4_recoder.sv
// Radix-4 Booth recoder: turns one overlapping multiplier triplet into
// control for the partial product (+/-M or +/-2M, or nothing).
module booth_radix4_recoder
    import multdiv_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       dbl,
    output logic       zero
);
    booth_digit_e digit;

    assign digit = booth_decode(triplet);
    assign neg   = (digit == BOOTH_NEG1) || (digit == BOOTH_NEG2);
    assign dbl   = (digit == BOOTH_POS2) || (digit == BOOTH_NEG2);
    assign zero  = (digit == BOOTH_ZERO);
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned.
// WIDTH must be even and at least 4. Operands are extended by two bits so the
// same datapath handles unsigned values; one extra digit covers that extension.
module booth_mult_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    booth_mult_seq_if.slave     bus
);
    localparam int ITER  = WIDTH / 2 + 1;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int EXT_W = WIDTH + 2;          // extended operand / Q width
    localparam int P_W   = WIDTH + 3;          // P and M width, room for +/-2M
    localparam int ACC_W = P_W + EXT_W + 1;    // {P, Q, q_-1}

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q, acc_shift;
    logic [P_W-1:0]     m_q, pp, p_cur, p_sum;
    logic               is_signed_q;
    logic [EXT_W-1:0]   a_ext, b_ext;
    logic [2*WIDTH-1:0] product_q, product_nxt;
    logic               overflow_q, overflow_nxt;
    logic               ready, busy, result_valid;
    logic               load, last_iter;
    logic               neg, dbl, zero;

    assign load      = ready && bus.start;
    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(ITER - 1));

    assign a_ext = bus.is_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                 : {2'b00, bus.multiplicand};
    assign b_ext = bus.is_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                 : {2'b00, bus.multiplier};

    booth_radix4_recoder u_recoder (
        .triplet (acc_q[2:0]),
        .neg     (neg),
        .dbl     (dbl),
        .zero    (zero)
    );

    assign p_cur = acc_q[ACC_W-1 -: P_W];
    assign pp    = dbl ? {m_q[P_W-2:0], 1'b0} : m_q;

    // Add or subtract the selected partial product into P.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
        p_sum = p_cur;
        if (!zero) begin
            p_sum = neg ? (p_cur - pp) : (p_cur + pp);
        end
    end

    assign acc_shift = $signed({p_sum, acc_q[EXT_W:0]}) >>> 2;

    // Low 2*WIDTH bits of {P,Q} after the last shift are the exact product.
    assign product_nxt  = acc_shift[2*WIDTH:1];
    assign overflow_nxt = is_signed_q
        ? (product_nxt[2*WIDTH-1:WIDTH] != {WIDTH{product_nxt[WIDTH-1]}})
        : (product_nxt[2*WIDTH-1:WIDTH] != '0);

    // State, iteration counter and registered result; reset aborts any operation.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_iter) begin
                product_q  <= product_nxt;
                overflow_q <= overflow_nxt;
            end
        end
    end

    // Accumulator and multiplicand: loaded on an accepted start, stepped in RUN.
    always_ff @(posedge clock) begin
        // NOTE: no reset here; these are always loaded before use, and the FSM reset alone discards work in flight.
        if (load) begin
            acc_q       <= {{P_W{1'b0}}, b_ext, 1'b0};
            m_q         <= {a_ext[EXT_W-1], a_ext};
            is_signed_q <= bus.is_signed;
        end else if (state_q == RUN) begin
            acc_q <= acc_shift;
        end
    end

    // Next-state and handshake decode; DONE accepts a new start directly.
    always_comb begin
        state_d      = state_q;
        ready        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                ready        = 1'b1;
                result_valid = 1'b1;
                state_d      = bus.start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready        = ready;
    assign bus.busy         = busy;
    assign bus.result_valid = result_valid;
    assign bus.product      = product_q;
    assign bus.overflow     = overflow_q;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, multi-cycle radix-4 Booth multiplier for the execute stage's mult path.
- Retires one radix-4 digit per clock.
- Supports signed and unsigned operands.
- Uses a start/ready/valid handshake and flags results that do not fit in WIDTH bits, so the pipeline can stall on busy and raise an exception.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.
- ITER, WIDTH/2+1, derived (localparam), number of radix-4 iterations; the extra digit covers unsigned mode.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with start
- multiplicand  in  WIDTH  operand A; latched with start
- multiplier  in  WIDTH  operand B; latched with start
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in RUN
- result_valid  out  1  one-cycle pulse in DONE
- product  out  2*WIDTH  full product; held from DONE until the next accepted start
- overflow  out  1  result does not fit in WIDTH bits; valid alongside product

Behaviour:
- Reset (synchronous, active-high):
  - Forces IDLE.
  - Sets ready=1, busy=0, result_valid=0, product=0, overflow=0, counter=0.
  - Overrides any operation in flight; no result is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start, latch operands and go to RUN.
  - RUN: after ITER iterations, go to DONE.
  - DONE: lasts one cycle, then IDLE; a start in DONE goes straight to RUN.
- Load edge (start accepted):
  - Extend each operand to WIDTH+2 bits: sign-extend if is_signed, else zero-extend.
  - Accumulator layout is {P (WIDTH+3 bits), Q (WIDTH+2 bits), q_-1 (1 bit)}.
  - Load P=0, Q=extended multiplier, q_-1=0.
  - Store the extended multiplicand M in a WIDTH+3-bit register.
  - Clear the counter.
- Each RUN edge:
  - Recode the triplet {Q[1], Q[0], q_-1}:
    - 000, 111 -> 0
    - 001, 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101, 110 -> -M
  - Add or subtract into P in WIDTH+3-bit two's complement.
  - Arithmetic-shift the whole accumulator right by 2.
  - Increment the counter.
  - On the edge where the counter reaches ITER-1, also go to DONE and register product and overflow.
- product = low 2*WIDTH bits of {P,Q} after the final shift. This is exact in both modes.
- overflow:
  - Signed mode: the product is not equal to the sign-extension of its low WIDTH bits.
  - Unsigned mode: product[2*WIDTH-1:WIDTH] != 0.
- Latency:
  - start is sampled at edge E0.
  - result_valid is high exactly in the cycle after edge E0+ITER (17 edges for WIDTH=32).
  - Throughput is one result per ITER+1 cycles.
- Handshake rules:
  - start while busy=1 is ignored; operands are not disturbed.
  - start held high continuously re-launches every ITER+1 cycles.
  - Operand inputs may change after the start edge without effect.
- Boundary conditions:
  - Zero operands give product 0, overflow 0.
  - Signed minimum values (e.g. -2^(WIDTH-1) squared) must be exact; the WIDTH+3-bit P guarantees no internal overflow for ±2M.
  - reset and start in the same cycle: reset wins.

Decomposition:
- Shared package (multdiv_pkg):
  - Booth digit encoding constants: BOOTH_ZERO, BOOTH_POS1, BOOTH_POS2, BOOTH_NEG1, BOOTH_NEG2.
  - FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
- One sub-module, booth_radix4_recoder (combinational):
  - Input: a 3-bit triplet.
  - Outputs: neg, dbl, zero.
  - The datapath forms the partial product from these as ±M or ±(M<<1).

Test Plan:
- Reset then idle: assert reset 2 cycles -> ready=1, busy=0, result_valid=0, product=0, overflow=0. Hold start=0 for 50 cycles -> outputs unchanged.
- Signed basics, WIDTH=32:
  - 7 x -3 -> product=64'hFFFF_FFFF_FFFF_FFEB, overflow=0, result_valid exactly 17 edges after the start edge, busy high for 17 cycles.
  - 0x7FFFFFFF x 2 -> product=64'h0000_0000_FFFF_FFFE, overflow=1.
- Corner values, signed:
  - 0x80000000 x 0x80000000 -> product=64'h4000_0000_0000_0000, overflow=1.
  - -1 x -1 -> product=1, overflow=0.
- Unsigned:
  - 0xFFFFFFFF x 0xFFFFFFFF -> product=64'hFFFF_FFFE_0000_0001, overflow=1.
  - 0x0001_0000 x 0x0000_FFFF -> product=64'h0000_0000_FFFF_0000, overflow=0.
- Handshake:
  - Pulse start with 5 x 6, then re-assert start with 9 x 9 during RUN -> the second request is ignored, product=30.
  - start in the DONE cycle with 9 x 9 -> accepted; product=81 after a further 17 edges.
- Reset mid-operation:
  - Assert reset 8 cycles into RUN -> next cycle IDLE, busy=0, product=0, no result_valid pulse.
  - A fresh 3 x 4 then completes with product=12.
- Random: 10k random operand and mode pairs at WIDTH=32 and WIDTH=8 -> product and overflow match a behavioural reference.
